lc3_pipe_controller: RTL and testbench



---
 rtl/lc3_pkg.sv | 50 +++++
 rtl/lc3_pipe_controller_mem_fsm.sv | 84 ++++++++
 rtl/lc3_pipe_controller.sv | 104 ++++++++++
 tb/tb_lc3_pipe_controller.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/lc3_pkg.sv
// Shared opcode constants, memory-interface encodings and instruction classifiers
// for the LC-3 pipeline controller.
package lc3_pkg;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  typedef enum logic [1:0] {
    MS_IND  = 2'd0,
    MS_RD   = 2'd1,
    MS_WR   = 2'd2,
    MS_IDLE = 2'd3
  } mem_state_e;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEM_IND = 2'd1,
    ST_MEM_ACC = 2'd2
  } fsm_state_e;

  function automatic logic is_mem_op(input logic [15:0] instr);
    case (instr[15:12])
      OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

  function automatic logic is_ind_op(input logic [15:0] instr);
    return (instr[15:12] == OP_LDI) || (instr[15:12] == OP_STI);
  endfunction

  function automatic logic is_store(input logic [15:0] instr);
    return (instr[15:12] == OP_ST) || (instr[15:12] == OP_STR) || (instr[15:12] == OP_STI);
  endfunction

  function automatic logic is_ctl_op(input logic [15:0] instr);
    return (instr[15:12] == OP_BR) || (instr[15:12] == OP_JMP);
  endfunction

endpackage

// File: rtl/lc3_pipe_controller_mem_fsm.sv
// Memory-access sequencer: RUN -> (MEM_IND) -> MEM_ACC -> RUN, with an optional
// watchdog that forces a return to RUN when complete_data never arrives.
module lc3_mem_fsm
  import lc3_pkg::*;
#(
  parameter int TIMEOUT = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_i,
  input  logic       ind_i,
  input  logic       store_i,
  input  logic       complete_data_i,
  output logic [1:0] mem_state_o,
  output logic       mem_busy_o,
  output logic       mem_wb_pulse_o,
  output logic       mem_fin_o
);

  localparam int TO_W = 16;

  fsm_state_e        state_q, state_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              timeout_hit;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_RUN;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // The watchdog spans the whole operation, including the indirect read.
  always_comb begin
    state_d        = state_q;
    to_cnt_d       = '0;
    mem_state_o    = MS_IDLE;
    mem_busy_o     = 1'b0;
    mem_wb_pulse_o = 1'b0;
    mem_fin_o      = 1'b0;
    timeout_hit    = (TIMEOUT > 0) && (to_cnt_q == TO_W'(TIMEOUT - 1));

    case (state_q)
      ST_RUN: begin
        if (start_i) state_d = ind_i ? ST_MEM_IND : ST_MEM_ACC;
      end
      ST_MEM_IND: begin
        mem_busy_o  = 1'b1;
        mem_state_o = MS_IND;
        to_cnt_d    = to_cnt_q + 1'b1;
        if (complete_data_i) begin
          state_d = ST_MEM_ACC;
        end else if (timeout_hit) begin
          state_d   = ST_RUN;
          mem_fin_o = 1'b1;
        end
      end
      ST_MEM_ACC: begin
        mem_busy_o  = 1'b1;
        mem_state_o = store_i ? MS_WR : MS_RD;
        to_cnt_d    = to_cnt_q + 1'b1;
        if (complete_data_i) begin
          state_d        = ST_RUN;
          mem_fin_o      = 1'b1;
          mem_wb_pulse_o = !store_i;
        end else if (timeout_hit) begin
          state_d   = ST_RUN;
          mem_fin_o = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (reset) begin
      mem_state_o    = MS_IDLE;
      mem_wb_pulse_o = 1'b0;
      mem_fin_o      = 1'b0;
    end
  end

endmodule

// File: rtl/lc3_pipe_controller.sv
// Stall/sequence controller for the 5-stage LC-3 pipe: stage enables, memory-op
// sequencing and branch hold/resolve.
module lc3_pipe_controller
  import lc3_pkg::*;
#(
  parameter int BR_STALL = 3,
  parameter int TIMEOUT  = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] IR,
  input  logic [15:0] IR_Exec,
  input  logic [2:0]  psr,
  input  logic        complete_instr,
  input  logic        complete_data,
  output logic        enable_fetch,
  output logic        enable_updatePC,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic [1:0]  mem_state,
  output logic        br_taken
);

  logic [2:0] br_cnt_q, br_cnt_d;
  logic       mem_done_q, mem_done_d;
  logic       ctl_done_q, ctl_done_d;
  logic       mem_entry, mem_busy, mem_wb_pulse, mem_fin;
  logic       br_trig, br_stall;

  assign mem_entry = !reset && !mem_busy && is_mem_op(IR_Exec) && !mem_done_q;

  lc3_mem_fsm #(.TIMEOUT(TIMEOUT)) u_mem_fsm (
    .clock           (clock),
    .reset           (reset),
    .start_i         (mem_entry),
    .ind_i           (is_ind_op(IR_Exec)),
    .store_i         (is_store(IR_Exec)),
    .complete_data_i (complete_data),
    .mem_state_o     (mem_state),
    .mem_busy_o      (mem_busy),
    .mem_wb_pulse_o  (mem_wb_pulse),
    .mem_fin_o       (mem_fin)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      br_cnt_q   <= '0;
      mem_done_q <= 1'b0;
      ctl_done_q <= 1'b0;
    end else begin
      br_cnt_q   <= br_cnt_d;
      mem_done_q <= mem_done_d;
      ctl_done_q <= ctl_done_d;
    end
  end

  always_comb begin
    enable_fetch     = 1'b0;
    enable_updatePC  = 1'b0;
    enable_decode    = 1'b0;
    enable_execute   = 1'b0;
    enable_writeback = 1'b0;
    br_taken         = 1'b0;
    br_trig          = 1'b0;
    br_stall         = 1'b0;
    br_cnt_d         = br_cnt_q;
    mem_done_d       = mem_done_q;
    ctl_done_d       = ctl_done_q;

    if (reset) begin
      br_cnt_d = '0;
    end else if (mem_busy) begin
      enable_writeback = mem_wb_pulse;
    end else if (!mem_entry) begin
      // The trigger cycle itself freezes Decode so the BR/JMP stays in IR
      // until it resolves BR_STALL cycles later.
      br_trig          = is_ctl_op(IR) && !ctl_done_q && (br_cnt_q == 3'd0);
      br_stall         = br_trig || (br_cnt_q != 3'd0);
      enable_execute   = 1'b1;
      enable_writeback = !(is_store(IR_Exec) || is_ctl_op(IR_Exec));
      if (!br_stall) begin
        enable_fetch    = complete_instr;
        enable_updatePC = complete_instr;
        enable_decode   = complete_instr;
      end
      if (br_trig) begin
        br_cnt_d = 3'(BR_STALL);
      end else if (br_cnt_q != 3'd0) begin
        br_cnt_d = br_cnt_q - 3'd1;
      end
      if (br_cnt_q == 3'd1) begin
        enable_updatePC = 1'b1;
        br_taken        = (IR[15:12] == OP_BR) ? |(IR[11:9] & psr) : 1'b1;
        ctl_done_d      = 1'b1;
      end
    end

    if (enable_decode)  ctl_done_d = 1'b0;
    if (enable_execute) mem_done_d = 1'b0;
    if (mem_fin)        mem_done_d = 1'b1;
  end

endmodule

// File: tb/tb_lc3_pipe_controller.sv
// Directed bench for lc3_pipe_controller: each step queues the expected outputs,
// drives one cycle of inputs, then pops and checks against the DUT.
module tb_lc3_pipe_controller;

  typedef struct packed {
    logic       f;
    logic       p;
    logic       d;
    logic       e;
    logic       w;
    logic [1:0] ms;
    logic       bt;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [15:0] IR, IR_Exec;
  logic [2:0]  psr;
  logic        complete_instr, complete_data;
  logic        enable_fetch, enable_updatePC, enable_decode, enable_execute, enable_writeback;
  logic [1:0]  mem_state;
  logic        br_taken;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  localparam logic [15:0] I_ADD  = 16'h1261;
  localparam logic [15:0] I_LDR  = 16'h6442;
  localparam logic [15:0] I_STI  = 16'hB5FF;
  localparam logic [15:0] I_BRNZ = 16'h0C05;
  localparam logic [15:0] I_JMP  = 16'hC1C0;
  localparam logic [15:0] I_LD   = 16'h2202;
  localparam logic [15:0] I_LDI  = 16'hA3FF;

  lc3_pipe_controller #(.BR_STALL(3), .TIMEOUT(0)) dut (
    .clock            (clock),
    .reset            (reset),
    .IR               (IR),
    .IR_Exec          (IR_Exec),
    .psr              (psr),
    .complete_instr   (complete_instr),
    .complete_data    (complete_data),
    .enable_fetch     (enable_fetch),
    .enable_updatePC  (enable_updatePC),
    .enable_decode    (enable_decode),
    .enable_execute   (enable_execute),
    .enable_writeback (enable_writeback),
    .mem_state        (mem_state),
    .br_taken         (br_taken)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t mk(input logic f, p, d, e, w, input logic [1:0] ms, input logic bt);
    exp_t r;
    r.f = f; r.p = p; r.d = d; r.e = e; r.w = w; r.ms = ms; r.bt = bt;
    return r;
  endfunction

  task automatic step(input logic rst, input logic [15:0] ir, input logic [15:0] ire,
                      input logic [2:0] ps, input logic ci, input logic cd,
                      input exp_t e, input string tag);
    exp_t obs;
    exp_t want;
    @(negedge clock);
    reset          = rst;
    IR             = ir;
    IR_Exec        = ire;
    psr            = ps;
    complete_instr = ci;
    complete_data  = cd;
    exp_q.push_back(e);
    #2;
    obs  = mk(enable_fetch, enable_updatePC, enable_decode, enable_execute,
              enable_writeback, mem_state, br_taken);
    want = exp_q.pop_front();
    checks++;
    assert (obs === want)
      else begin
        errors++;
        $error("FAIL %s observed f/p/d/e/w=%b%b%b%b%b ms=%0d bt=%b expected f/p/d/e/w=%b%b%b%b%b ms=%0d bt=%b",
               tag, obs.f, obs.p, obs.d, obs.e, obs.w, obs.ms, obs.bt,
               want.f, want.p, want.d, want.e, want.w, want.ms, want.bt);
      end
  endtask

  initial begin
    exp_t all1, zero, brh, ind0;
    checks = 0;
    errors = 0;
    reset = 1'b1; IR = I_ADD; IR_Exec = I_ADD; psr = 3'b000;
    complete_instr = 1'b1; complete_data = 1'b0;
    all1 = mk(1, 1, 1, 1, 1, 2'd3, 0);
    zero = mk(0, 0, 0, 0, 0, 2'd3, 0);
    brh  = mk(0, 0, 0, 1, 1, 2'd3, 0);
    ind0 = mk(0, 0, 0, 0, 0, 2'd0, 0);

    // reset then ADD stream
    step(1, I_ADD, I_ADD, 3'b000, 1, 0, zero, "reset");
    for (int i = 0; i < 3; i++)
      step(0, I_ADD, I_ADD, 3'b000, 1, 0, all1, "add_run");

    // LDR: detect, two MEM_ACC cycles, back to RUN without re-access
    step(0, I_ADD, I_LDR, 3'b000, 1, 0, zero, "ldr_detect");
    step(0, I_ADD, I_LDR, 3'b000, 1, 0, mk(0, 0, 0, 0, 0, 2'd1, 0), "ldr_acc_wait");
    step(0, I_ADD, I_LDR, 3'b000, 1, 1, mk(0, 0, 0, 0, 1, 2'd1, 0), "ldr_acc_done");
    step(0, I_ADD, I_LDR, 3'b000, 1, 0, all1, "ldr_run_no_retrigger");
    step(0, I_ADD, I_ADD, 3'b000, 1, 0, all1, "ldr_after");

    // STI: indirect read then write, never a writeback
    step(0, I_ADD, I_STI, 3'b000, 1, 0, zero, "sti_detect");
    step(0, I_ADD, I_STI, 3'b000, 1, 1, ind0, "sti_ind");
    step(0, I_ADD, I_STI, 3'b000, 1, 1, mk(0, 0, 0, 0, 0, 2'd2, 0), "sti_wr");
    step(0, I_ADD, I_STI, 3'b000, 1, 0, mk(1, 1, 1, 1, 0, 2'd3, 0), "sti_run");
    step(0, I_ADD, I_ADD, 3'b000, 1, 0, all1, "sti_after");

    // BRnz with Z set: taken
    step(0, I_BRNZ, I_ADD, 3'b010, 1, 0, brh, "br1_trig");
    step(0, I_BRNZ, I_ADD, 3'b010, 1, 0, brh, "br1_cnt3");
    step(0, I_BRNZ, I_ADD, 3'b010, 1, 0, brh, "br1_cnt2");
    step(0, I_BRNZ, I_ADD, 3'b010, 1, 0, mk(0, 1, 0, 1, 1, 2'd3, 1), "br1_resolve");
    step(0, I_BRNZ, I_ADD, 3'b010, 1, 0, all1, "br1_no_retrigger");
    step(0, I_ADD,  I_ADD, 3'b010, 1, 0, all1, "br1_after");

    // BRnz with P set: not taken; complete_instr low mid-stall has no effect
    step(0, I_BRNZ, I_ADD, 3'b001, 1, 0, brh, "br2_trig");
    step(0, I_BRNZ, I_ADD, 3'b001, 0, 0, brh, "br2_cnt3");
    step(0, I_BRNZ, I_ADD, 3'b001, 0, 0, brh, "br2_cnt2");
    step(0, I_BRNZ, I_ADD, 3'b001, 1, 0, mk(0, 1, 0, 1, 1, 2'd3, 0), "br2_resolve");
    step(0, I_BRNZ, I_ADD, 3'b001, 1, 0, all1, "br2_no_retrigger");
    step(0, I_ADD,  I_ADD, 3'b001, 1, 0, all1, "br2_after");

    // JMP in IR with LD in IR_Exec: memory first, then branch stall
    step(0, I_JMP, I_LD,  3'b000, 1, 0, zero, "jmp_ld_detect");
    step(0, I_JMP, I_LD,  3'b000, 1, 0, mk(0, 0, 0, 0, 0, 2'd1, 0), "jmp_ld_wait");
    step(0, I_JMP, I_LD,  3'b000, 1, 1, mk(0, 0, 0, 0, 1, 2'd1, 0), "jmp_ld_done");
    step(0, I_JMP, I_LD,  3'b000, 1, 0, brh, "jmp_trig");
    step(0, I_JMP, I_ADD, 3'b000, 1, 0, brh, "jmp_cnt3");
    step(0, I_JMP, I_ADD, 3'b000, 1, 0, brh, "jmp_cnt2");
    step(0, I_JMP, I_ADD, 3'b000, 1, 0, mk(0, 1, 0, 1, 1, 2'd3, 1), "jmp_resolve");
    step(0, I_JMP, I_ADD, 3'b000, 1, 0, all1, "jmp_no_retrigger");
    step(0, I_ADD, I_ADD, 3'b000, 1, 0, all1, "jmp_after");

    // reset while in MEM_IND
    step(0, I_ADD, I_LDI, 3'b000, 1, 0, zero, "ldi_detect");
    step(0, I_ADD, I_LDI, 3'b000, 1, 0, ind0, "ldi_ind");
    step(1, I_ADD, I_LDI, 3'b000, 1, 0, zero, "ldi_reset_a");
    step(1, I_ADD, I_LDI, 3'b000, 1, 1, zero, "ldi_reset_b");
    step(0, I_ADD, I_JMP, 3'b111, 1, 1, mk(1, 1, 1, 1, 0, 2'd3, 0), "post_reset_clean");
    step(0, I_ADD, I_ADD, 3'b111, 1, 0, all1, "post_reset_run");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
